dispatch_ctrl: RTL

Per-cycle dispatch controller for the 3-wide R10K front end. It decides how many instructions of the current 3-slot bundle may dispatch, in program order, given physical-register free-list, ROB and RS availability. It drives the free list's `DispatchEN` and holds dispatch off for a fixed window after a branch-mispredict recovery. It sits between the fetch/decode buffer and the Freelist/ROB/RS allocation ports, and keeps a saturating stall counter for performance debug.

---
 rtl/dispatch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dispatch_ctrl.sv
// In-order dispatch admission for a 3-wide bundle against free-list, ROB and RS
// availability, with a post-recovery blackout window, halt latch and stall counter.
module dispatch_ctrl #(
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned ROB_W          = 6,
    parameter int unsigned RS_W           = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       inst_valid,
    input  logic [2:0]       needs_dest,
    input  logic [4:0]       fl_avail,
    input  logic             fl_full,
    input  logic [ROB_W-1:0] rob_avail,
    input  logic [RS_W-1:0]  rs_avail,
    input  logic             BPRecoverEN,
    input  logic             halt_in,
    output logic [2:0]       DispatchEN,
    output logic [2:0]       dispatch_valid,
    output logic [1:0]       dispatch_num,
    output logic             stall,
    output logic [1:0]       state,
    output logic [15:0]      stall_cycles
);

    localparam int unsigned FL_W   = 6;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ROB_CW = (ROB_W > 2) ? ROB_W : 2;
    localparam int unsigned RS_CW  = (RS_W > 2) ? RS_W : 2;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FL_W-1:0]  fl_eff;
    logic [2:0]       admit;
    logic [1:0]       inst_cnt, dest_cnt, inst_try, dest_try;
    logic             open;
    logic             go;

    // Contiguous admission from slot 2 downward; first failing slot closes the prefix.
    always_comb begin
        fl_eff   = fl_full ? FL_W'(32) : FL_W'(fl_avail);
        admit    = '0;
        inst_cnt = '0;
        dest_cnt = '0;
        inst_try = '0;
        dest_try = '0;
        open     = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            inst_try = inst_cnt + 2'd1;
            dest_try = dest_cnt + 2'(needs_dest[i]);
            if (open && inst_valid[i]
                && (ROB_CW'(inst_try) <= ROB_CW'(rob_avail))
                && (RS_CW'(inst_try) <= RS_CW'(rs_avail))
                && (FL_W'(dest_try) <= fl_eff)) begin
                admit[i] = 1'b1;
                inst_cnt = inst_try;
                dest_cnt = dest_try;
            end else begin
                open = 1'b0;
            end
        end
    end

    // Free-list head is rewound whenever BPRecoverEN is high, so nothing may allocate then.
    always_comb begin
        go             = !reset && (state_q == RUN) && !BPRecoverEN;
        dispatch_valid = go ? admit : 3'b000;
        DispatchEN     = dispatch_valid & needs_dest;
        dispatch_num   = 2'(dispatch_valid[2]) + 2'(dispatch_valid[1]) + 2'(dispatch_valid[0]);
        stall          = !reset && inst_valid[2] && (dispatch_num == 2'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (BPRecoverEN) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_W'(RECOVER_CYCLES);
                end else if (halt_in) begin
                    state_d = HALTED;
                end
            end
            RECOVER: begin
                if (BPRecoverEN) begin
                    cnt_d = CNT_W'(RECOVER_CYCLES);
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating stall counter, RUN-state stalls only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if ((state_q == RUN) && stall && !BPRecoverEN
                     && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    assign state = state_q;

endmodule
